// File: rtl/rgb_pkg.sv
// rgb_pkg: shared types and constants for the colour-class expander.
//   colour_t              one colour channel
//   ch_e                  channel index CH0/CH1/CH2
//   LVL_ADDR_LO/HI(ch)    level-write address of a channel's lo/hi level
//   LVL_ADDR_MAX          highest non-reserved level address
//   CODE_BIT_CHx          which code bit selects channel x (matches compressor)
package rgb_pkg;

  localparam int COLOUR_DEPTH = 8;
  localparam int NUM_CH       = 3;

  typedef logic [COLOUR_DEPTH-1:0] colour_t;

  typedef enum logic [1:0] {
    CH0 = 2'd0,
    CH1 = 2'd1,
    CH2 = 2'd2
  } ch_e;

  localparam logic [2:0] LVL_ADDR_MAX = 3'd5;

  // Compressor packs channel 0 into the MSB of the code.
  localparam logic [1:0] CODE_BIT_CH0 = 2'd2;
  localparam logic [1:0] CODE_BIT_CH1 = 2'd1;
  localparam logic [1:0] CODE_BIT_CH2 = 2'd0;

  function automatic logic [2:0] LVL_ADDR_LO(input int unsigned ch);
    return 3'(ch << 1);
  endfunction

  function automatic logic [2:0] LVL_ADDR_HI(input int unsigned ch);
    return 3'((ch << 1) | 1);
  endfunction

  function automatic logic [1:0] CODE_BIT(input int unsigned ch);
    case (ch)
      0:       return CODE_BIT_CH0;
      1:       return CODE_BIT_CH1;
      default: return CODE_BIT_CH2;
    endcase
  endfunction

endpackage

// File: rtl/rgb_level_bank.sv
// rgb_level_bank: lo/hi reconstruction levels for the three channels.
// Optional feature macro: RGB_EXPAND_DOUBLE_BUFFER_EN
//   defined   - writes land in a shadow bank and set pending; the active bank
//               takes the shadow contents on a block boundary when pending.
//   undefined - writes update the active levels directly.
// Ports:
//   clk_i, rst_n_i      clock, async active-low reset
//   wr_i/addr_i/data_i  level write (addr 6,7 ignored)
//   boundary_i          a code is accepted on the last pixel of a block
//   lo_o, hi_o          active lo/hi level per channel ([0] = ch0)
module rgb_level_bank #(
  parameter int COLOUR_DEPTH = 8
) (
  input  logic                               clk_i,
  input  logic                               rst_n_i,
  input  logic                               wr_i,
  input  logic [2:0]                         addr_i,
  input  logic [COLOUR_DEPTH-1:0]            data_i,
  input  logic                               boundary_i,
  output logic [2:0][COLOUR_DEPTH-1:0]       lo_o,
  output logic [2:0][COLOUR_DEPTH-1:0]       hi_o
);
  import rgb_pkg::*;

  typedef logic [2:0][COLOUR_DEPTH-1:0] lvl_t;

  lvl_t act_lo_q, act_hi_q;
  lvl_t wr_base_lo, wr_base_hi;  // bank the write lands in
  lvl_t wr_lo_d, wr_hi_d;

  // Reserved addresses match no channel, so they fall through untouched.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_wr
    assign wr_lo_d[c] = (wr_i && addr_i == LVL_ADDR_LO(c)) ? data_i : wr_base_lo[c];
    assign wr_hi_d[c] = (wr_i && addr_i == LVL_ADDR_HI(c)) ? data_i : wr_base_hi[c];
  end

`ifdef RGB_EXPAND_DOUBLE_BUFFER_EN
  lvl_t sh_lo_q, sh_hi_q;
  logic pend_q;
  logic wr_ok;
  logic swap;

  assign wr_base_lo = sh_lo_q;
  assign wr_base_hi = sh_hi_q;
  assign wr_ok      = wr_i && (addr_i <= LVL_ADDR_MAX);
  assign swap       = boundary_i && pend_q;

  // Active copies the pre-write shadow; a write in the swap cycle keeps
  // pending set so it is picked up at the next boundary.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_lo_q <= '0;
      act_hi_q <= '1;
      sh_lo_q  <= '0;
      sh_hi_q  <= '1;
      pend_q   <= 1'b0;
    end else begin
      if (swap) begin
        act_lo_q <= sh_lo_q;
        act_hi_q <= sh_hi_q;
      end
      sh_lo_q <= wr_lo_d;
      sh_hi_q <= wr_hi_d;
      if (wr_ok)     pend_q <= 1'b1;
      else if (swap) pend_q <= 1'b0;
    end
  end
`else
  logic unused_boundary;

  assign wr_base_lo      = act_lo_q;
  assign wr_base_hi      = act_hi_q;
  assign unused_boundary = boundary_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      act_lo_q <= '0;
      act_hi_q <= '1;
    end else begin
      act_lo_q <= wr_lo_d;
      act_hi_q <= wr_hi_d;
    end
  end
`endif

  assign lo_o = act_lo_q;
  assign hi_o = act_hi_q;

endmodule

// File: rtl/rgb_expand.sv
// rgb_expand: expands 3-bit colour-class codes into 24-bit RGB pixels using
// per-channel programmable lo/hi levels. Blocks of AVERAGE_OVER pixels are
// counted; block_first_out flags the first pixel of each block.
// Optional feature macro: RGB_EXPAND_DOUBLE_BUFFER_EN (see rgb_level_bank).
// Ports:
//   clk_in, rst_n_in                      clock, async active-low reset
//   code_in/code_valid_in/code_ready_out  code input handshake
//   lvl_wr_in/lvl_addr_in/lvl_data_in     level programming (never stalls)
//   rgb_out/rgb_valid_out/rgb_ready_in    pixel output handshake
//   block_first_out                       pixel is first of its block
module rgb_expand #(
  parameter int COLOUR_DEPTH = 8,
  parameter int AVERAGE_OVER = 1024
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic [2:0]                code_in,
  input  logic                      code_valid_in,
  output logic                      code_ready_out,
  input  logic                      lvl_wr_in,
  input  logic [2:0]                lvl_addr_in,
  input  logic [COLOUR_DEPTH-1:0]   lvl_data_in,
  output logic [3*COLOUR_DEPTH-1:0] rgb_out,
  output logic                      rgb_valid_out,
  input  logic                      rgb_ready_in,
  output logic                      block_first_out
);
  import rgb_pkg::*;

  localparam int CNT_W = $clog2(AVERAGE_OVER);

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic [2:0][COLOUR_DEPTH-1:0]   lo_act, hi_act;
  logic [2:0][COLOUR_DEPTH-1:0]   pix_d, pix_q;
  logic                           vld_q, first_q;
  logic                           accept, boundary;

  assign code_ready_out = !vld_q || rgb_ready_in;
  assign accept         = code_valid_in && code_ready_out;
  // AVERAGE_OVER is a power of two: the last pixel is the all-ones count and
  // the increment wraps to zero on its own.
  assign boundary       = accept && (&cnt_q);
  assign cnt_d          = cnt_q + 1'b1;

  rgb_level_bank #(
    .COLOUR_DEPTH(COLOUR_DEPTH)
  ) u_bank (
    .clk_i      (clk_in),
    .rst_n_i    (rst_n_in),
    .wr_i       (lvl_wr_in),
    .addr_i     (lvl_addr_in),
    .data_i     (lvl_data_in),
    .boundary_i (boundary),
    .lo_o       (lo_act),
    .hi_o       (hi_act)
  );

  for (genvar c = 0; c < NUM_CH; c++) begin : g_dec
    assign pix_d[c] = code_in[CODE_BIT(c)] ? hi_act[c] : lo_act[c];
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt_q   <= '0;
      pix_q   <= '0;
      vld_q   <= 1'b0;
      first_q <= 1'b0;
    end else if (accept) begin
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      first_q <= (cnt_q == '0);
      vld_q   <= 1'b1;
    end else if (rgb_ready_in) begin
      vld_q   <= 1'b0;
    end
  end

  assign rgb_out         = pix_q;
  assign rgb_valid_out   = vld_q;
  assign block_first_out = first_q;

endmodule

// File: tb/tb_rgb_expand.sv
module tb_rgb_expand;
  localparam int CD = 8;
  localparam int AO = 16;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic [2:0]      code_in;
  logic            code_valid_in;
  logic            code_ready_out;
  logic            lvl_wr_in;
  logic [2:0]      lvl_addr_in;
  logic [CD-1:0]   lvl_data_in;
  logic [3*CD-1:0] rgb_out;
  logic            rgb_valid_out;
  logic            rgb_ready_in;
  logic            block_first_out;

  always #5 clk_in = ~clk_in;

  rgb_expand #(.COLOUR_DEPTH(CD), .AVERAGE_OVER(AO)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .code_in         (code_in),
    .code_valid_in   (code_valid_in),
    .code_ready_out  (code_ready_out),
    .lvl_wr_in       (lvl_wr_in),
    .lvl_addr_in     (lvl_addr_in),
    .lvl_data_in     (lvl_data_in),
    .rgb_out         (rgb_out),
    .rgb_valid_out   (rgb_valid_out),
    .rgb_ready_in    (rgb_ready_in),
    .block_first_out (block_first_out)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: level tables indexed by address (2*ch + hi), a pixel
  // count modulo AO, and the pixel currently expected at the output.
  int              act[6];
  int              sh[6];
  bit              pend;
  int              pix;
  bit              ev, ef;
  logic [3*CD-1:0] erx;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) begin
      act[i] = (i % 2 == 1) ? (1 << CD) - 1 : 0;
      sh[i]  = act[i];
    end
    pend = 0; pix = 0; ev = 0; ef = 0; erx = '0;
  endtask

  // Called just after a rising edge, inputs still hold pre-edge values.
  task automatic model_step();
    bit rdy, acc, wok;
    rdy = !ev || rgb_ready_in;
    acc = code_valid_in && rdy;
    wok = lvl_wr_in && (lvl_addr_in <= 3'd5);
    if (acc) begin
      for (int ch = 0; ch < 3; ch++)
        erx[ch*CD +: CD] = CD'(act[2*ch + int'(code_in[2-ch])]);
      ef = (pix == 0);
      ev = 1;
    end else if (rgb_ready_in) begin
      ev = 0;
    end
`ifdef RGB_EXPAND_DOUBLE_BUFFER_EN
    if (acc && pix == AO-1 && pend) begin
      act  = sh;
      pend = 0;
    end
    if (wok) begin
      sh[lvl_addr_in] = int'(lvl_data_in);
      pend = 1;
    end
`else
    if (wok) act[lvl_addr_in] = int'(lvl_data_in);
`endif
    if (acc) pix = (pix + 1) % AO;
  endtask

  task automatic cyc();
    @(posedge clk_in);
    model_step();
    @(negedge clk_in);
    chk("ready", code_ready_out, !ev || rgb_ready_in);
    chk("valid", rgb_valid_out, ev);
    if (ev) begin
      chk("rgb", rgb_out, erx);
      chk("first", block_first_out, ef);
    end
  endtask

  task automatic acc1(input logic [2:0] c, input bit wr, input logic [2:0] a, input logic [CD-1:0] d);
    code_in = c; code_valid_in = 1'b1; rgb_ready_in = 1'b1;
    lvl_wr_in = wr; lvl_addr_in = a; lvl_data_in = d;
    cyc();
    lvl_wr_in = 1'b0;
  endtask

  task automatic run_to(input int t);
    for (int k = 0; k < 2*AO && pix != t; k++)
      acc1(3'($urandom_range(0, 7)), 1'b0, 3'd0, '0);
  endtask

  initial begin
    int nfirst;
    logic [3*CD-1:0] snap;
    rst_n_in = 1'b0; code_in = '0; code_valid_in = 1'b0; rgb_ready_in = 1'b1;
    lvl_wr_in = 1'b0; lvl_addr_in = '0; lvl_data_in = '0;
    model_reset();
    repeat (2) @(negedge clk_in);
    chk("rst_rgb", rgb_out, 0);
    chk("rst_valid", rgb_valid_out, 0);
    chk("rst_first", block_first_out, 0);
    chk("rst_ready", code_ready_out, 1);
    rst_n_in = 1'b1;

    // First pixel after reset
    acc1(3'b101, 1'b0, 3'd0, '0);
    chk("t1_rgb", rgb_out, 24'hFF00FF);
    chk("t1_first", block_first_out, 1);

    // Mid-block ch0 level writes
    code_valid_in = 1'b0;
    lvl_wr_in = 1'b1; lvl_addr_in = 3'd0; lvl_data_in = 8'h20; cyc();
    lvl_addr_in = 3'd1; lvl_data_in = 8'hE0; cyc();
    lvl_wr_in = 1'b0;
    acc1(3'b000, 1'b0, 3'd0, '0);
`ifdef RGB_EXPAND_DOUBLE_BUFFER_EN
    chk("t2_pre_ch0", rgb_out[7:0], 8'h00);
`else
    chk("t2_pre_ch0", rgb_out[7:0], 8'h20);
`endif
    run_to(0);
    acc1(3'b000, 1'b0, 3'd0, '0);
    chk("t2_post_ch0", rgb_out[7:0], 8'h20);
    chk("t2_post_first", block_first_out, 1);

    // Two full blocks: exactly two first-pixel flags
    run_to(0);
    nfirst = 0;
    for (int i = 0; i < 2*AO; i++) begin
      acc1(3'($urandom_range(0, 7)), 1'b0, 3'd0, '0);
      if (block_first_out) nfirst++;
    end
    chk("first_cnt", nfirst, 2);

    // Output stall with a pending code
    snap = rgb_out;
    code_in = 3'($urandom_range(0, 7)); code_valid_in = 1'b1; rgb_ready_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("stall_hold", rgb_out, snap);
      chk("stall_ready", code_ready_out, 0);
    end
    rgb_ready_in = 1'b1;
    cyc();
    cyc();

    // Level write in the swap cycle
    acc1(3'b000, 1'b1, 3'd3, 8'h77);
    run_to(AO-1);
    acc1(3'($urandom_range(0, 7)), 1'b1, 3'd3, 8'h55);
    acc1(3'b010, 1'b0, 3'd0, '0);
`ifdef RGB_EXPAND_DOUBLE_BUFFER_EN
    chk("t5_blk1_ch1", rgb_out[15:8], 8'h77);
`else
    chk("t5_blk1_ch1", rgb_out[15:8], 8'h55);
`endif
    run_to(0);
    acc1(3'b010, 1'b0, 3'd0, '0);
    chk("t5_blk2_ch1", rgb_out[15:8], 8'h55);

    // Reserved-address write across two boundaries
    acc1(3'b000, 1'b1, 3'd7, 8'h99);
    run_to(0);
    acc1(3'b000, 1'b0, 3'd0, '0);
    run_to(0);
    acc1(3'b111, 1'b0, 3'd0, '0);
    chk("t6_levels", rgb_out, 24'hFF55E0);

    // Random traffic with a mid-stream reset
    for (int i = 0; i < 600; i++) begin
      code_in       = 3'($urandom_range(0, 7));
      code_valid_in = ($urandom_range(0, 3) != 0);
      rgb_ready_in  = ($urandom_range(0, 3) != 0);
      lvl_wr_in     = ($urandom_range(0, 7) == 0);
      lvl_addr_in   = 3'($urandom_range(0, 7));
      lvl_data_in   = CD'($urandom_range(0, 255));
      if (i == 300) begin
        rst_n_in = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_rgb", rgb_out, 0);
        chk("mid_rst_valid", rgb_valid_out, 0);
        chk("mid_rst_first", block_first_out, 0);
        chk("mid_rst_ready", code_ready_out, 1);
        @(negedge clk_in);
        rst_n_in = 1'b1;
      end
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/rgb_expand.md
# rgb_expand

Decompressor for the 3-bit colour-class stream produced by the marker-detect RGB compressor. Each accepted 3-bit code becomes an approximate 24-bit RGB pixel by selecting, per channel, a programmable "low" or "high" reconstruction level. Levels are double-buffered and swapped on block boundaries of `AVERAGE_OVER` pixels, matching the compressor's averaging period. The block sits on the display/debug path, after the marker-detect compressed bus.

## Interface
- `COLOUR_DEPTH`, 8: bits per colour channel.
- `AVERAGE_OVER`, 1024: pixels per block; a power of two ≥ 2.

- `clk_in`  in  1  clock; all logic is on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `code_in`  in  3  compressed code. Bit 2 selects channel 0, `rgb_out[CD-1:0]`. Bit 1 selects channel 1. Bit 0 selects channel 2, `rgb_out[3CD-1:2CD]`.
- `code_valid_in`  in  1  `code_in` is valid.
- `code_ready_out`  out  1  the block can accept a code.
- `lvl_wr_in`  in  1  level write strobe.
- `lvl_addr_in`  in  3  level index: 2·ch + hi (0 = ch0 lo … 5 = ch2 hi); 6 and 7 are reserved.
- `lvl_data_in`  in  COLOUR_DEPTH  level value.
- `rgb_out`  out  3·COLOUR_DEPTH  reconstructed pixel.
- `rgb_valid_out`  out  1  `rgb_out` is valid.
- `rgb_ready_in`  in  1  downstream accepts the pixel.
- `block_first_out`  out  1  qualifies `rgb_out`; high for the first pixel of a block.

## Operation
- A code is accepted in a cycle where `code_valid_in` and `code_ready_out` are both high.
- `code_ready_out = !rgb_valid_out || rgb_ready_in`. The output is a single register stage with no skid buffer.
- Decode on accept: for each channel, the code bit selects the active level. Bit = 1 selects the hi level; bit = 0 selects the lo level.
- Pixel counter:
  - width `$clog2(AVERAGE_OVER)`.
  - Increments on every accept and wraps from `AVERAGE_OVER-1` to 0.
  - `block_first_out` is registered with the pixel and equals (counter == 0 at accept).
- Level writes:
  - Go to the shadow bank and set `pending`.
  - Writes to reserved addresses 6 and 7 are ignored and do not set `pending`.
- Swap condition: accept with counter == `AVERAGE_OVER-1` and `pending` set.
- On swap:
  - active ← shadow and `pending` is cleared.
  - The accepted code itself decodes with the old active levels.
  - The next accepted code uses the new levels.
- A level write in the swap cycle:
  - Active receives the shadow contents from before the write.
  - The write lands in shadow and `pending` stays set, so it takes effect at the following boundary.
- No codes means no swap. Level writes never stall the data path.

## Timing
- Reset values:
  - `rgb_out` = 0, `rgb_valid_out` = 0, `block_first_out` = 0.
  - `code_ready_out` = 1.
  - Counter = 0, `pending` = 0.
  - Both banks: lo = 0, hi = 2^CD−1.
- Latency: an accept at edge N gives `rgb_valid_out` = 1 with the pixel after edge N.
- Back-to-back accepts give one pixel per cycle while `rgb_ready_in` = 1.
- While `rgb_valid_out && !rgb_ready_in`:
  - `rgb_out` and `block_first_out` hold stable.
  - `code_ready_out` = 0.
- `rgb_valid_out` falls after a handshake only when no new code is accepted in the same cycle.
- Reset asserted mid-block returns every register to its reset value immediately. Any in-flight pixel is dropped and `pending` is lost.

## Configuration
- Macro: `RGB_EXPAND_DOUBLE_BUFFER_EN`.
- Defined: shadow/active banks and boundary swap as described above.
- Undefined:
  - No shadow bank and no `pending`.
  - Writes update the active level at the write edge.
  - A code accepted in the same cycle as the write decodes with the old value; later codes use the new value.
  - Counter and `block_first_out` are unchanged.

## Structure
- Package `rgb_pkg`:
  - `colour_t` (logic [COLOUR_DEPTH-1:0]).
  - Channel enum `CH0`/`CH1`/`CH2`.
  - Constants `LVL_ADDR_LO(ch)` / `LVL_ADDR_HI(ch)` for indices 0–5 and `LVL_ADDR_MAX` = 5.
  - Code-bit-to-channel mapping constants shared with the compressor.
- Sub-module `rgb_level_bank`: holds shadow and active levels, `pending`, the write decode and the swap. The macro is confined to this sub-module.
- Top level: counter, handshake and output register.

## Test plan
- Reset, then code 3'b101 with ready held high → `rgb_out` = {ch2 = FF, ch1 = 00, ch0 = FF} one cycle later, and `block_first_out` = 1.
- Write ch0 lo = 0x20 and ch0 hi = 0xE0 mid-block, then code 3'b000 → ch0 = 0x00 until the boundary. The first pixel of the next block shows ch0 = 0x20. Without the macro, ch0 = 0x20 immediately.
- Stream 2·`AVERAGE_OVER` codes → `block_first_out` high exactly on pixels 0 and `AVERAGE_OVER`, and the counter wraps correctly.
- Hold `rgb_ready_in` = 0 for 5 cycles with `code_valid_in` = 1 → `code_ready_out` = 0, `rgb_out` stable, no codes lost or duplicated, and the output order is preserved.
- Level write in the swap cycle (ch1 hi = 0x55) → the next block uses the earlier shadow value. The block after that uses 0x55.
- Write to address 7, then reach a boundary with no other writes → no swap and levels unchanged. Also assert reset mid-stream → all outputs return to their reset values.
